// File: rtl/obstacle_scroller_if.sv
// Signal bundle between the obstacle scroller and its environment.
// The master side drives video timing, control and pitch samples. The slave side returns the obstacle state.
interface obstacle_scroller_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        start_in;
  logic        pause_in;
  logic        freq_valid_in;
  logic [15:0] freq_in;
  logic [7:0]  note_in;
  logic [12:0] x_out;
  logic [15:0] freq_out;
  logic [7:0]  note_out;
  logic        active_out;
  logic        pass_pulse_out;
  logic [7:0]  score_out;

  modport master (
    output hcount_in, vcount_in, start_in, pause_in, freq_valid_in, freq_in, note_in,
    input  x_out, freq_out, note_out, active_out, pass_pulse_out, score_out
  );

  modport slave (
    input  hcount_in, vcount_in, start_in, pause_in, freq_valid_in, freq_in, note_in,
    output x_out, freq_out, note_out, active_out, pass_pulse_out, score_out
  );
endinterface

// File: rtl/obstacle_scroller.sv
// Scrolls one pillar obstacle left once per frame and respawns it at the right edge.
// The gap frequency and note are latched only at start or respawn, and passed obstacles are counted.
module obstacle_scroller #(
  parameter int unsigned SCREEN_WIDTH = 1280,
  parameter int unsigned SPEED        = 4,
  parameter int unsigned TICK_LINE    = 721,
  parameter int unsigned FREQ_MAX     = 2047
) (
  input logic               clk,
  input logic               rst,
  obstacle_scroller_if.slave bus
);

  localparam logic [12:0] X_SPAWN = 13'(SCREEN_WIDTH);
  localparam logic [12:0] X_STEP  = 13'(SPEED);
  localparam logic [9:0]  V_TICK  = 10'(TICK_LINE);
  localparam logic [15:0] F_MAX   = 16'(FREQ_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t      state;
  logic [12:0] x_q;
  logic [15:0] freq_q;
  logic [7:0]  note_q;
  logic [15:0] pend_freq;
  logic [7:0]  pend_note;
  logic        active_q;
  logic        pass_q;
  logic [7:0]  score_q;

  logic        tick;
  logic [15:0] freq_clamped;
  logic [15:0] load_f;
  logic [7:0]  load_n;

  // A sample arriving on the load cycle bypasses the pending register.
  always_comb begin
    tick         = (bus.hcount_in == '0) && (bus.vcount_in == V_TICK);
    freq_clamped = (bus.freq_in > F_MAX) ? F_MAX : bus.freq_in;
    load_f       = bus.freq_valid_in ? freq_clamped : pend_freq;
    load_n       = bus.freq_valid_in ? bus.note_in : pend_note;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= X_SPAWN;
      freq_q    <= '0;
      note_q    <= '0;
      pend_freq <= '0;
      pend_note <= '0;
      active_q  <= 1'b0;
      pass_q    <= 1'b0;
      score_q   <= '0;
    end else begin
      pass_q <= 1'b0;
      if (bus.freq_valid_in) begin
        pend_freq <= freq_clamped;
        pend_note <= bus.note_in;
      end
      case (state)
        IDLE: begin
          x_q <= X_SPAWN;
          if (bus.start_in) begin
            state    <= RUN;
            active_q <= 1'b1;
            freq_q   <= load_f;
            note_q   <= load_n;
            score_q  <= '0;
          end
        end
        RUN: begin
          // Pause has priority, so a tick arriving with pause_in high does not move the obstacle.
          if (bus.pause_in) begin
            state <= PAUSED;
          end else if (tick) begin
            if (x_q >= X_STEP) begin
              x_q <= x_q - X_STEP;
            end else begin
              x_q    <= X_SPAWN;
              freq_q <= load_f;
              note_q <= load_n;
              pass_q <= 1'b1;
              if (score_q != '1) score_q <= score_q + 8'd1;
            end
          end
        end
        PAUSED: begin
          if (!bus.pause_in) state <= RUN;
        end
        default: begin
          state    <= IDLE;
          active_q <= 1'b0;
          x_q      <= X_SPAWN;
        end
      endcase
    end
  end

  assign bus.x_out          = x_q;
  assign bus.freq_out       = freq_q;
  assign bus.note_out       = note_q;
  assign bus.active_out     = active_q;
  assign bus.pass_pulse_out = pass_q;
  assign bus.score_out      = score_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Scoreboard bench for obstacle_scroller: a full-width instance and a narrow instance get identical stimulus.
// A flight-count reference model predicts every cycle's outputs, and a monitor compares them.
module tb_obstacle_scroller;
  localparam int W_MAIN  = 1280;
  localparam int W_SMALL = 18;
  localparam int SPD     = 4;
  localparam int TL      = 721;
  localparam int FMAX    = 2047;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  obstacle_scroller_if bus_m ();
  obstacle_scroller_if bus_s ();

  obstacle_scroller #(.SCREEN_WIDTH(W_MAIN), .SPEED(SPD), .TICK_LINE(TL), .FREQ_MAX(FMAX))
    dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  obstacle_scroller #(.SCREEN_WIDTH(W_SMALL), .SPEED(SPD), .TICK_LINE(TL), .FREQ_MAX(FMAX))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  // mode: 0 idle, 1 running, 2 paused; position is width - SPD*moves
  typedef struct {
    int mode; int moves; int freq; int note; int pf; int pn; int score; bit pulse;
  } model_t;
  typedef struct {
    int x; int freq; int note; bit active; bit pulse; int score;
  } exp_t;

  model_t mm, ms;
  exp_t   q_m[$];
  exp_t   q_s[$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;

  function automatic model_t model_reset();
    model_t m;
    m.mode = 0; m.moves = 0; m.freq = 0; m.note = 0;
    m.pf = 0; m.pn = 0; m.score = 0; m.pulse = 1'b0;
    return m;
  endfunction

  function automatic model_t step(model_t m, int w, bit r, int h, int v, bit st, bit pa,
                                  bit fv, int f, int n);
    model_t o;
    int clamped, lf, ln;
    bit tk;
    if (r) return model_reset();
    o = m;
    o.pulse = 1'b0;
    clamped = (f > FMAX) ? FMAX : f;
    lf = fv ? clamped : m.pf;
    ln = fv ? n : m.pn;
    if (fv) begin o.pf = clamped; o.pn = n; end
    tk = (h == 0) && (v == TL);
    if (m.mode == 0) begin
      if (st) begin o.mode = 1; o.freq = lf; o.note = ln; o.score = 0; end
    end else if (m.mode == 1) begin
      if (pa) o.mode = 2;
      else if (tk) begin
        if (w - SPD * m.moves >= SPD) o.moves = m.moves + 1;
        else begin
          o.moves = 0; o.freq = lf; o.note = ln; o.pulse = 1'b1;
          o.score = (m.score >= 255) ? 255 : m.score + 1;
        end
      end
    end else begin
      if (!pa) o.mode = 1;
    end
    return o;
  endfunction

  function automatic exp_t view(model_t m, int w);
    exp_t e;
    e.x = w - SPD * m.moves; e.freq = m.freq; e.note = m.note;
    e.active = (m.mode != 0); e.pulse = m.pulse; e.score = m.score;
    return e;
  endfunction

  task automatic drive(bit r, int h, int v, bit st, bit pa, bit fv, int f, int n);
    @(negedge clk);
    rst = r;
    bus_m.hcount_in = 11'(h); bus_s.hcount_in = 11'(h);
    bus_m.vcount_in = 10'(v); bus_s.vcount_in = 10'(v);
    bus_m.start_in = st; bus_s.start_in = st;
    bus_m.pause_in = pa; bus_s.pause_in = pa;
    bus_m.freq_valid_in = fv; bus_s.freq_valid_in = fv;
    bus_m.freq_in = 16'(f); bus_s.freq_in = 16'(f);
    bus_m.note_in = 8'(n); bus_s.note_in = 8'(n);
    mm = step(mm, W_MAIN, r, h, v, st, pa, fv, f, n);
    ms = step(ms, W_SMALL, r, h, v, st, pa, fv, f, n);
    q_m.push_back(view(mm, W_MAIN));
    q_s.push_back(view(ms, W_SMALL));
  endtask

  task automatic ticks(int k, bit pa);
    repeat (k) drive(1'b0, 0, TL, 1'b0, pa, 1'b0, 0, 0);
  endtask

  task automatic quiet(bit pa);
    drive(1'b0, 17, 300, 1'b0, pa, 1'b0, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic spot(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic compare(string name, exp_t e, int x, int f, int n, bit a, bit p, int s);
    checks++;
    if (x != e.x || f != e.freq || n != e.note || a != e.active || p != e.pulse || s != e.score) begin
      failures++;
      $display("FAIL %s cyc=%0d got x=%0d freq=%0d note=%0d active=%0d pulse=%0d score=%0d expected x=%0d freq=%0d note=%0d active=%0d pulse=%0d score=%0d",
               name, cyc, x, f, n, a, p, s, e.x, e.freq, e.note, e.active, e.pulse, e.score);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q_m.size() > 0) begin
        e = q_m.pop_front();
        compare("sb_main", e, int'(bus_m.x_out), int'(bus_m.freq_out), int'(bus_m.note_out),
                bus_m.active_out, bus_m.pass_pulse_out, int'(bus_m.score_out));
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        compare("sb_small", e, int'(bus_s.x_out), int'(bus_s.freq_out), int'(bus_s.note_out),
                bus_s.active_out, bus_s.pass_pulse_out, int'(bus_s.score_out));
      end
    end
  end

  task automatic random_phase(int cycles, bit allow_rst, int tick_pct);
    bit r, st, pa, fv;
    int h, v, f, n;
    pa = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      r = allow_rst && ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < tick_pct) begin h = 0; v = TL; end
      else begin h = $urandom_range(0, 2047); v = $urandom_range(0, 1023); end
      if (pa) pa = ($urandom_range(0, 4) != 0);
      else    pa = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 19) == 0);
      fv = ($urandom_range(0, 5) == 0);
      f  = ($urandom_range(0, 3) == 0) ? $urandom_range(2040, 65535) : $urandom_range(0, 2100);
      n  = $urandom_range(0, 255);
      drive(r, h, v, st, pa, fv, f, n);
    end
  endtask

  initial begin : stimulus
    mm = model_reset();
    ms = model_reset();
    drive(1'b1, 5, 5, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 5, 5, 1'b0, 1'b0, 1'b0, 0, 0);

    // three frames without start: obstacle stays parked
    repeat (3) begin ticks(1, 1'b0); quiet(1'b0); quiet(1'b0); end
    settle();
    spot("idle_x", int'(bus_m.x_out), 1280);
    spot("idle_active", int'(bus_m.active_out), 0);
    spot("idle_score", int'(bus_m.score_out), 0);
    spot("idle_freq", int'(bus_m.freq_out), 0);

    drive(1'b0, 17, 300, 1'b0, 1'b0, 1'b1, 800, 8'h2A);
    drive(1'b0, 17, 300, 1'b1, 1'b0, 1'b0, 0, 0);
    settle();
    spot("start_active", int'(bus_m.active_out), 1);
    spot("start_freq", int'(bus_m.freq_out), 800);
    spot("start_note", int'(bus_m.note_out), 8'h2A);
    ticks(10, 1'b0);
    settle();
    spot("x_after_10", int'(bus_m.x_out), 1240);

    drive(1'b0, 17, 300, 1'b0, 1'b0, 1'b1, 5000, 8'h33);
    ticks(310, 1'b0);
    settle();
    spot("x_at_edge", int'(bus_m.x_out), 0);
    spot("freq_in_flight", int'(bus_m.freq_out), 800);
    ticks(1, 1'b0);
    settle();
    spot("respawn_x", int'(bus_m.x_out), 1280);
    spot("respawn_freq_clamped", int'(bus_m.freq_out), 2047);
    spot("respawn_note", int'(bus_m.note_out), 8'h33);
    spot("respawn_pulse", int'(bus_m.pass_pulse_out), 1);
    spot("respawn_score", int'(bus_m.score_out), 1);
    quiet(1'b0);
    settle();
    spot("pulse_single", int'(bus_m.pass_pulse_out), 0);

    ticks(320, 1'b0);
    drive(1'b0, 0, TL, 1'b0, 1'b0, 1'b1, 300, 8'h11);
    settle();
    spot("bypass_freq", int'(bus_m.freq_out), 300);
    spot("bypass_score", int'(bus_m.score_out), 2);

    ticks(20, 1'b0);
    settle();
    spot("pre_pause_x", int'(bus_m.x_out), 1200);
    ticks(6, 1'b1);
    settle();
    spot("paused_x", int'(bus_m.x_out), 1200);
    quiet(1'b0);
    ticks(1, 1'b0);
    settle();
    spot("resume_x", int'(bus_m.x_out), 1196);

    ticks(3, 1'b0);
    drive(1'b1, 0, TL, 1'b0, 1'b0, 1'b0, 0, 0);
    settle();
    spot("rst_x", int'(bus_m.x_out), 1280);
    spot("rst_score", int'(bus_m.score_out), 0);
    spot("rst_active", int'(bus_m.active_out), 0);
    spot("rst_pulse", int'(bus_m.pass_pulse_out), 0);
    quiet(1'b0);

    random_phase(1500, 1'b1, 50);
    drive(1'b0, 17, 300, 1'b1, 1'b0, 1'b0, 0, 0);
    random_phase(5000, 1'b0, 70);
    quiet(1'b0);
    settle();
    spot("small_score_saturated", int'(bus_s.score_out), 255);

    settle();
    settle();
    spot("queues_drained", q_m.size() + q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
